ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-006 SHALL have port imem_ready, input, 1, memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port redirect, input, 1, a taken branch or jump; valid for one cycle.
REQ-009 SHALL have port redirect_pc, input, 32, the target address, sampled when redirect=1.
REQ-010 SHALL have port inst_valid, output, 1, meaning that inst, pc, imm16 and ext_sign are valid.
REQ-011 SHALL have port inst_ready, input, 1, downstream accept.
REQ-012 SHALL have ports inst, output, 32 (held instruction) and pc, output, 32 (address of inst).
REQ-013 SHALL have ports imm16, output, 16 (inst[15:0]) and ext_sign, output, 1, which drive the half and signal inputs of the immediate extender.

Function
REQ-014 SHALL implement states FETCH (imem_req=1, waiting for imem_ready) and HOLD (inst_valid=1, waiting for inst_ready).
REQ-015 In FETCH, imem_addr SHALL equal fetch_pc and SHALL remain stable until imem_ready=1.
REQ-016 In FETCH, when imem_ready=1 and no discard is pending: latch inst<=imem_rdata and pc<=fetch_pc, set fetch_pc<=fetch_pc+4 (mod 2^32, wrapping from 32'hFFFF_FFFC to 0), and go to HOLD.
REQ-017 The fetch latency SHALL be one cycle: inst_valid rises on the clock edge that samples imem_ready=1.
REQ-018 In HOLD, imem_req SHALL be 0; when inst_ready=1, go to FETCH on the next edge. There is no bypass, so throughput is at most one instruction per two cycles.
REQ-019 inst, pc, imm16 and ext_sign SHALL remain stable while inst_valid=1 and inst_ready=0.
REQ-020 If redirect=1 in HOLD, set fetch_pc<=redirect_pc[31:2],2'b00 and go to FETCH; the held instruction SHALL be dropped (inst_valid=0 next cycle) even if inst_ready=1.
REQ-021 If redirect=1 in FETCH with imem_ready=0, set fetch_pc<=target and set discard=1; imem_addr SHALL keep the old address until the outstanding response arrives.
REQ-022 If discard=1 and imem_ready=1, the response SHALL be dropped, discard cleared, and the state SHALL stay FETCH with imem_addr=fetch_pc (the target).
REQ-023 If redirect=1 and imem_ready=1 in the same FETCH cycle, the response SHALL be dropped, fetch_pc<=target, and the state SHALL stay FETCH.
REQ-024 If redirect=1 while discard=1, the newer target SHALL overwrite fetch_pc; discard SHALL stay set.
REQ-025 ext_sign SHALL be 0 when inst[31:26] is 6'h0C, 6'h0D, 6'h0E or 6'h0F (andi/ori/xori/lui), and 1 otherwise.
REQ-026 imm16 SHALL equal inst[15:0], decoded combinationally from the held register.

Reset
REQ-027 While rst=1: state=FETCH, fetch_pc=RESET_PC, discard=0, inst=0, pc=0, inst_valid=0, imem_req=0. The block SHALL drop any response that arrives during reset.
REQ-028 In the first cycle after rst falls, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL drop that transaction; the first fetch after reset is from RESET_PC.

Verification
REQ-030 Reset release, memory ready after 2 cycles with rdata=32'h3421_00FF -> inst_valid=1, pc=32'h3000, imm16=16'h00FF, ext_sign=0.
REQ-031 Fetch of 32'h8C01_FFFC (lw) held 3 cycles with inst_ready=0 -> outputs stable, imem_req=0, ext_sign=1; after accept, imem_addr=32'h3004.
REQ-032 Redirect to 32'h0000_4000 during a pending fetch, with ready 2 cycles later -> old word dropped, inst_valid stays 0, next imem_addr=32'h4000.
REQ-033 redirect and imem_ready in the same cycle, target 32'h0000_5002 -> word dropped, imem_addr=32'h5000.
REQ-034 Redirect to 32'hFFFF_FFFC, fetch completes -> next imem_addr=32'h0 (wrap).
REQ-035 rst pulsed while imem_req=1 -> all outputs reset; after release, imem_addr=RESET_PC and the late response is ignored.

Source files
------------

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch stage: FETCH issues a read and HOLD presents the word downstream.
// A redirect that arrives while a read is in flight marks that response for discard.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [15:0] imm16,
    output logic        ext_sign
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pend_addr, pend_addr_n;
    logic [31:0] inst_n, pc_n;
    logic        discard, discard_n;
    logic [31:0] target;
    logic [1:0]  redirect_unused;

    assign target          = {redirect_pc[31:2], 2'b00};
    assign redirect_unused = redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            pend_addr <= RESET_PC;
            discard   <= 1'b0;
            inst      <= '0;
            pc        <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            pend_addr <= pend_addr_n;
            discard   <= discard_n;
            inst      <= inst_n;
            pc        <= pc_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        pend_addr_n = pend_addr;
        discard_n   = discard;
        inst_n      = inst;
        pc_n        = pc;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (discard || redirect) begin
                        // stale or superseded response: drop it and keep fetching
                        discard_n = 1'b0;
                        if (redirect)
                            fetch_pc_n = target;
                    end else begin
                        inst_n     = imem_rdata;
                        pc_n       = fetch_pc;
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = HOLD;
                    end
                end else if (redirect) begin
                    // the bus still owns the old address until its response returns
                    fetch_pc_n = target;
                    if (!discard)
                        pend_addr_n = fetch_pc;
                    discard_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_n = target;
                    state_n    = FETCH;
                end else if (inst_ready) begin
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    assign imem_req   = (state == FETCH) && !rst;
    assign imem_addr  = discard ? pend_addr : fetch_pc;
    assign inst_valid = (state == HOLD);
    assign imm16      = inst[15:0];
    assign ext_sign   = !(inst[31:26] inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
endmodule
